// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf -- elastic pipeline-stage register with valid/ready handshake.
//
// Sits between two pipeline stages.  The payload (in_data) is cleared to 0
// (a NOP) whenever the stage holds no live entry.  The keep field (in_keep,
// e.g. PC+4) is never zeroed by a bubble or flush.
//
// Parameters
//   DATA_W : payload width; reads 0 on bubble/flush
//   KEEP_W : sideband width; preserved across bubbles/flush
//   SKID   : 0 = single register, in_ready depends combinationally on out_ready
//            1 = main register + one skid entry, in_ready is a register decode
//
// Ports
//   clk, reset       : rising-edge clock, synchronous active-high reset
//   flush            : synchronous kill of every held entry
//   in_valid/in_ready/in_data/in_keep     : upstream handshake and payload
//   out_valid/out_ready/out_data/out_keep : downstream handshake and payload
//   occupancy        : live entries held (0..1 for SKID=0, 0..2 for SKID=1)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high.  in_fire = in_valid & in_ready, out_fire = out_valid & out_ready.
// Valid is never withdrawn by this stage except by flush or reset.  Entries
// leave in arrival order.
//
// Edge priority: reset > flush > normal transfer.  While flush is high,
// in_ready is 0, so an offered entry is never silently lost.
module pipe_stage_buf #(
  parameter int DATA_W = 32,
  parameter int KEEP_W = 32,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [KEEP_W-1:0] in_keep,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [KEEP_W-1:0] out_keep,
  output logic [1:0]        occupancy
);

  logic in_fire;
  logic out_fire;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  if (SKID == 0) begin : g_single
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic [KEEP_W-1:0] keep_q,  keep_d;

    // The register may take a new entry when it is empty, or when its
    // current entry is leaving in the same cycle.
    assign in_ready = (!valid_q | out_ready) & !flush;

    always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      keep_d  = keep_q;
      if (flush) begin
        valid_d = 1'b0;
        data_d  = '0;
      end else if (in_fire) begin
        valid_d = 1'b1;
        data_d  = in_data;
        keep_d  = in_keep;
      end else if (out_fire) begin
        // Bubble: the payload becomes a NOP, and keep still shows the
        // entry that just left.
        valid_d = 1'b0;
        data_d  = '0;
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        valid_q <= 1'b0;
        data_q  <= '0;
        keep_q  <= '0;
      end else begin
        valid_q <= valid_d;
        data_q  <= data_d;
        keep_q  <= keep_d;
      end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_keep  = keep_q;
    assign occupancy = {1'b0, valid_q};

  end else begin : g_skid
    typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
    } state_e;

    state_e            state_q;
    logic              valid_q;
    logic [1:0]        occ_q;
    logic [DATA_W-1:0] main_data_q;
    logic [KEEP_W-1:0] main_keep_q;
    logic [DATA_W-1:0] skid_data_q;
    logic [KEEP_W-1:0] skid_keep_q;

    // The skid entry is full only in ST_TWO.  in_ready decodes the registered
    // state alone, so there is no combinational path from out_ready.
    assign in_ready = (state_q != ST_TWO) & !flush;

    always_ff @(posedge clk) begin
      if (reset) begin
        state_q     <= ST_EMPTY;
        valid_q     <= 1'b0;
        occ_q       <= 2'd0;
        main_data_q <= '0;
        main_keep_q <= '0;
        skid_data_q <= '0;
        skid_keep_q <= '0;
      end else if (flush) begin
        // main_keep_q is deliberately left alone.
        state_q     <= ST_EMPTY;
        valid_q     <= 1'b0;
        occ_q       <= 2'd0;
        main_data_q <= '0;
        skid_data_q <= '0;
        skid_keep_q <= '0;
      end else begin
        case (state_q)
          ST_EMPTY: begin
            if (in_fire) begin
              state_q     <= ST_ONE;
              valid_q     <= 1'b1;
              occ_q       <= 2'd1;
              main_data_q <= in_data;
              main_keep_q <= in_keep;
            end
          end
          ST_ONE: begin
            if (in_fire && out_fire) begin
              // Full-throughput pass: replace the departing entry.
              main_data_q <= in_data;
              main_keep_q <= in_keep;
            end else if (in_fire) begin
              state_q     <= ST_TWO;
              occ_q       <= 2'd2;
              skid_data_q <= in_data;
              skid_keep_q <= in_keep;
            end else if (out_fire) begin
              state_q     <= ST_EMPTY;
              valid_q     <= 1'b0;
              occ_q       <= 2'd0;
              main_data_q <= '0;
            end
          end
          ST_TWO: begin
            // No input is accepted here, so only a departure matters.
            if (out_fire) begin
              state_q     <= ST_ONE;
              occ_q       <= 2'd1;
              main_data_q <= skid_data_q;
              main_keep_q <= skid_keep_q;
              skid_data_q <= '0;
              skid_keep_q <= '0;
            end
          end
          default: begin
            state_q     <= ST_EMPTY;
            valid_q     <= 1'b0;
            occ_q       <= 2'd0;
            main_data_q <= '0;
          end
        endcase
      end
    end

    assign out_valid = valid_q;
    assign out_data  = main_data_q;
    assign out_keep  = main_keep_q;
    // occupancy mirrors the FSM state, which makes the state visible.
    assign occupancy = occ_q;
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Drives one SKID=0 and one SKID=1 instance of pipe_stage_buf from the same
// inputs.  Each instance is compared every cycle against a queue model: the
// stage is a FIFO with a depth limit, and the keep output tracks the head
// entry that was last held.
module tb_pipe_stage_buf;

  localparam int DW = 32;
  localparam int KW = 32;
  localparam int W  = DW + KW;

  logic          clk;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic [KW-1:0] in_keep;
  logic          out_ready;

  logic [1:0]    in_ready_w;
  logic [1:0]    out_valid_w;
  logic [DW-1:0] out_data_w [2];
  logic [KW-1:0] out_keep_w [2];
  logic [1:0]    occ_w      [2];

  // Scoreboard: entries held by each instance, as {keep, data}, oldest first.
  logic [W-1:0]  exp_q0[$];
  logic [W-1:0]  exp_q1[$];
  logic [KW-1:0] last_keep [2];

  int checks;
  int failures;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  pipe_stage_buf #(.DATA_W(DW), .KEEP_W(KW), .SKID(0)) u_dut0 (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready_w[0]),
    .in_data   (in_data),
    .in_keep   (in_keep),
    .out_valid (out_valid_w[0]),
    .out_ready (out_ready),
    .out_data  (out_data_w[0]),
    .out_keep  (out_keep_w[0]),
    .occupancy (occ_w[0])
  );

  pipe_stage_buf #(.DATA_W(DW), .KEEP_W(KW), .SKID(1)) u_dut1 (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready_w[1]),
    .in_data   (in_data),
    .in_keep   (in_keep),
    .out_valid (out_valid_w[1]),
    .out_ready (out_ready),
    .out_data  (out_data_w[1]),
    .out_keep  (out_keep_w[1]),
    .occupancy (occ_w[1])
  );

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Compares one instance against its model mid-cycle, then advances the
  // model by what happens at the coming edge.
  task automatic model_cycle(input int v);
    logic [W-1:0]  q[$];
    logic          e_valid, e_ready, i_fire, o_fire;
    logic [DW-1:0] e_data;
    int            depth;
    if (v == 0) q = exp_q0; else q = exp_q1;
    depth   = (v == 0) ? 1 : 2;
    e_valid = (q.size() > 0);
    e_data  = e_valid ? q[0][DW-1:0] : '0;
    if (flush)       e_ready = 1'b0;
    else if (v == 1) e_ready = (q.size() < depth);
    else             e_ready = (q.size() == 0) || out_ready;

    check($sformatf("s%0d_out_valid", v), 64'(out_valid_w[v]), 64'(e_valid));
    check($sformatf("s%0d_out_data", v),  64'(out_data_w[v]),  64'(e_data));
    check($sformatf("s%0d_out_keep", v),  64'(out_keep_w[v]),  64'(last_keep[v]));
    check($sformatf("s%0d_occupancy", v), 64'(occ_w[v]),       64'(q.size()));
    check($sformatf("s%0d_in_ready", v),  64'(in_ready_w[v]),  64'(e_ready));

    i_fire = in_valid & e_ready;
    o_fire = e_valid & out_ready;
    if (reset) begin
      q.delete();
      last_keep[v] = '0;
    end else if (flush) begin
      q.delete();
    end else begin
      if (o_fire) void'(q.pop_front());
      if (i_fire) q.push_back({in_keep, in_data});
      if (q.size() > 0) last_keep[v] = q[0][W-1:DW];
    end
    if (v == 0) exp_q0 = q; else exp_q1 = q;
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic r, input logic f, input logic iv,
                      input logic [DW-1:0] d, input logic [KW-1:0] k,
                      input logic ordy);
    reset     = r;
    flush     = f;
    in_valid  = iv;
    in_data   = d;
    in_keep   = k;
    out_ready = ordy;
    @(negedge clk);
    model_cycle(0);
    model_cycle(1);
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    checks       = 0;
    failures     = 0;
    last_keep[0] = '0;
    last_keep[1] = '0;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0;
    in_data = '0; in_keep = '0; out_ready = 1'b0;
    // One unchecked edge takes both instances out of their power-up X state.
    @(posedge clk);
    #1;

    // Reset held while an entry is offered.
    step(1, 0, 1, 32'hDEAD, 32'h0, 1);
    step(1, 0, 1, 32'hDEAD, 32'h0, 1);

    // Back-to-back streaming with downstream always ready.
    for (int i = 1; i <= 8; i++) step(0, 0, 1, 32'(i), 32'(4 * i), 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);

    // Backpressure: A, B and C offered while the downstream is stalled.
    step(0, 0, 1, 32'hA, 32'h100, 0);
    step(0, 0, 1, 32'hB, 32'h104, 0);
    step(0, 0, 1, 32'hC, 32'h108, 0);
    step(0, 0, 1, 32'hC, 32'h108, 1);
    step(0, 0, 1, 32'hC, 32'h108, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);

    // Bubble: one entry is consumed, followed by an idle cycle.
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 32'h55, 32'h1004, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);

    // Flush while full, with 0x77 offered during the flush cycle.
    step(0, 0, 1, 32'h11, 32'h2000, 0);
    step(0, 0, 1, 32'h22, 32'h2004, 0);
    step(0, 1, 1, 32'h77, 32'h2008, 0);
    step(0, 0, 1, 32'h77, 32'h2008, 0);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);

    // Replace path: the entry leaves and a new one enters in the same cycle.
    step(0, 0, 1, 32'h31, 32'h3000, 0);
    step(0, 0, 1, 32'h32, 32'h3004, 1);
    step(0, 0, 1, 32'h33, 32'h3008, 1);
    step(0, 0, 0, 0, 0, 1);

    // Randomized traffic with occasional flush and reset.
    for (int n = 0; n < 1500; n++) begin
      step($urandom_range(0, 49) == 0,
           $urandom_range(0, 9) == 0,
           $urandom_range(0, 9) < 7,
           32'($urandom), 32'($urandom),
           $urandom_range(0, 9) < 6);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
